// File: rtl/write_back.sv
// MEM/WB pipeline latch and write-back data select; drives the register-file write port of decode.
// Latency: inputs captured on a clk edge appear on the outputs combinationally after that edge.
// Backpressure: in_enable=0 holds the latch (stall); in_flush=1 loads a bubble and overrides in_enable.
//
// Ports: clk/reset (async, active-high); in_* = MEM-stage results and control;
// RegWrite/write_data/write_register = register-file write port to decode.
// Optional feature: define WB_RETIRE_COUNT_EN to add the 32-bit out_retired counter port.
module write_back #(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_enable,
    input  logic           in_flush,
    input  logic           in_valid,
    input  logic [len-1:0] in_alu_result,
    input  logic [len-1:0] in_read_data,
    input  logic [len-1:0] in_pc_link,
    input  logic [4:0]     in_write_register,
    input  logic           in_RegWrite,
    input  logic           in_MemtoReg,
    input  logic           in_link,
    input  logic [1:0]     in_load_size,
    input  logic           in_load_unsigned,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]    out_retired,
`endif
    output logic           RegWrite,
    output logic [len-1:0] write_data,
    output logic [4:0]     write_register
);

    logic           valid_q,          valid_d;
    logic [len-1:0] alu_result_q,     alu_result_d;
    logic [len-1:0] read_data_q,      read_data_d;
    logic [len-1:0] pc_link_q,        pc_link_d;
    logic [4:0]     write_register_q, write_register_d;
    logic           reg_write_q,      reg_write_d;
    logic           mem_to_reg_q,     mem_to_reg_d;
    logic           link_q,           link_d;
    logic [1:0]     load_size_q,      load_size_d;
    logic           load_unsigned_q,  load_unsigned_d;

    // Next-state of the latch: flush beats enable; only valid/RegWrite need
    // clearing for a bubble, the data fields are simply held.
    always_comb begin
        valid_d          = valid_q;
        alu_result_d     = alu_result_q;
        read_data_d      = read_data_q;
        pc_link_d        = pc_link_q;
        write_register_d = write_register_q;
        reg_write_d      = reg_write_q;
        mem_to_reg_d     = mem_to_reg_q;
        link_d           = link_q;
        load_size_d      = load_size_q;
        load_unsigned_d  = load_unsigned_q;
        if (in_flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (in_enable) begin
            valid_d          = in_valid;
            alu_result_d     = in_alu_result;
            read_data_d      = in_read_data;
            pc_link_d        = in_pc_link;
            write_register_d = in_write_register;
            reg_write_d      = in_RegWrite;
            mem_to_reg_d     = in_MemtoReg;
            link_d           = in_link;
            load_size_d      = in_load_size;
            load_unsigned_d  = in_load_unsigned;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q          <= 1'b0;
            alu_result_q     <= '0;
            read_data_q      <= '0;
            pc_link_q        <= '0;
            write_register_q <= '0;
            reg_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
            link_q           <= 1'b0;
            load_size_q      <= 2'b00;
            load_unsigned_q  <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            alu_result_q     <= alu_result_d;
            read_data_q      <= read_data_d;
            pc_link_q        <= pc_link_d;
            write_register_q <= write_register_d;
            reg_write_q      <= reg_write_d;
            mem_to_reg_q     <= mem_to_reg_d;
            link_q           <= link_d;
            load_size_q      <= load_size_d;
            load_unsigned_q  <= load_unsigned_d;
        end
    end

    // Load extraction: little-endian lanes selected by the address offset.
    // Halfword uses offset[1] only; misaligned halves are not trapped.
    logic [7:0]     byte_lane;
    logic [15:0]    half_lane;
    logic [len-1:0] load_data;

    always_comb begin
        byte_lane = read_data_q[7:0];
        case (alu_result_q[1:0])
            2'd0: byte_lane = read_data_q[7:0];
            2'd1: byte_lane = read_data_q[15:8];
            2'd2: byte_lane = read_data_q[23:16];
            2'd3: byte_lane = read_data_q[31:24];
            default: byte_lane = read_data_q[7:0];
        endcase
        half_lane = alu_result_q[1] ? read_data_q[31:16] : read_data_q[15:0];

        load_data = read_data_q;
        case (load_size_q)
            2'b01: load_data = {{16{half_lane[15] & ~load_unsigned_q}}, half_lane};
            2'b10: load_data = {{24{byte_lane[7] & ~load_unsigned_q}}, byte_lane};
            default: load_data = read_data_q;   // word, and 11 treated as word
        endcase
    end

    always_comb begin
        if (link_q)
            write_data = pc_link_q;
        else if (mem_to_reg_q)
            write_data = load_data;
        else
            write_data = alu_result_q;
        write_register = write_register_q;
        // $0 is hardwired zero, so a write to it is dropped here rather than in decode.
        RegWrite = valid_q & reg_write_q & (write_register_q != 5'd0);
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    // Counts only edges that actually capture a real instruction; wraps naturally.
    always_comb begin
        retired_d = retired_q;
        if (in_enable && !in_flush && in_valid)
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired_q <= '0;
        else
            retired_q <= retired_d;
    end

    assign out_retired = retired_q;
`endif

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: ALU/load/link select, $0 suppression, stall, flush, async reset.
module tb_write_back;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_enable, in_flush, in_valid;
    logic [31:0] in_alu_result, in_read_data, in_pc_link;
    logic [4:0]  in_write_register;
    logic        in_RegWrite, in_MemtoReg, in_link;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic        RegWrite;
    logic [31:0] write_data;
    logic [4:0]  write_register;
    logic [31:0] out_retired;

    int checks   = 0;
    int failures = 0;
    int exp_ret  = 0;

    always #5 clk = ~clk;

    write_back #(.len(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_enable        (in_enable),
        .in_flush         (in_flush),
        .in_valid         (in_valid),
        .in_alu_result    (in_alu_result),
        .in_read_data     (in_read_data),
        .in_pc_link       (in_pc_link),
        .in_write_register(in_write_register),
        .in_RegWrite      (in_RegWrite),
        .in_MemtoReg      (in_MemtoReg),
        .in_link          (in_link),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
`ifdef WB_RETIRE_COUNT_EN
        .out_retired      (out_retired),
`endif
        .RegWrite         (RegWrite),
        .write_data       (write_data),
        .write_register   (write_register)
    );

`ifndef WB_RETIRE_COUNT_EN
    assign out_retired = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rw, input logic [4:0] wr,
                             input logic [31:0] wd);
        check({tag, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, rw});
        check({tag, ".write_register"}, {27'd0, write_register}, {27'd0, wr});
        check({tag, ".write_data"}, write_data, wd);
    endtask

    task automatic check_ret(input string tag);
`ifdef WB_RETIRE_COUNT_EN
        check({tag, ".out_retired"}, out_retired, exp_ret);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // One clock edge; the model of the retire counter advances with it.
    task automatic step();
        if (!reset && in_enable && !in_flush && in_valid) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] pcl, input logic [4:0] wr, input logic rw,
                         input logic m2r, input logic lnk, input logic [1:0] sz,
                         input logic uns);
        in_valid = v; in_alu_result = alu; in_read_data = rd; in_pc_link = pcl;
        in_write_register = wr; in_RegWrite = rw; in_MemtoReg = m2r; in_link = lnk;
        in_load_size = sz; in_load_unsigned = uns;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_enable = 1'b1; in_flush = 1'b0;
        drive(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        #1;
        // Reset state, with live inputs and edges occurring under reset.
        check_out("reset", 1'b0, 5'd0, 32'd0);
        step();
        check_out("reset_edge", 1'b0, 5'd0, 32'd0);
        exp_ret = 0;
        check_ret("reset");
        reset = 1'b0;

        // ALU write.
        drive(1'b1, 32'h0000_0007, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        check_out("alu", 1'b1, 5'd1, 32'h0000_0007);

        // Loads from 0x80FF7F01.
        drive(1'b1, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step(); check("lb_off3", write_data, 32'hFFFF_FF80);
        drive(1'b1, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
        step(); check("lbu_off3", write_data, 32'h0000_0080);
        drive(1'b1, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step(); check("lb_off0", write_data, 32'h0000_0001);
        drive(1'b1, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step(); check("lb_off1", write_data, 32'h0000_007F);
        drive(1'b1, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step(); check("lb_off2", write_data, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
        step(); check("lbu_off2", write_data, 32'h0000_00FF);
        drive(1'b1, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        step(); check("lh_off2", write_data, 32'hFFFF_80FF);
        drive(1'b1, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
        step(); check("lhu_off3", write_data, 32'h0000_80FF);
        drive(1'b1, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
        step(); check("lhu_off0", write_data, 32'h0000_7F01);
        drive(1'b1, 32'h0000_1000, 32'h8000_8001, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        step(); check("lh_off0_neg", write_data, 32'hFFFF_8001);
        drive(1'b1, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        step(); check_out("lw", 1'b1, 5'd2, 32'h80FF_7F01);
        drive(1'b1, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        step(); check("size11_word", write_data, 32'h80FF_7F01);

        // $0 suppression: data and index still driven.
        drive(1'b1, 32'h0000_0004, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        check_out("reg0", 1'b0, 5'd0, 32'h0000_0004);

        // Link overrides MemtoReg.
        drive(1'b1, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_0048, 5'd31, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        step();
        check_out("link", 1'b1, 5'd31, 32'h0000_0048);

        // Bubble input and instruction without RegWrite.
        drive(1'b0, 32'h0000_0055, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        check_out("invalid", 1'b0, 5'd3, 32'h0000_0055);
        drive(1'b1, 32'h0000_0066, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        check_out("no_regwrite", 1'b0, 5'd4, 32'h0000_0066);
        check_ret("mid");

        // Stall: capture A then hold three cycles with different inputs applied.
        drive(1'b1, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        check_out("instrA", 1'b1, 5'd5, 32'h0000_1234);
        in_enable = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0100, 5'd7, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 1'b1, 5'd5, 32'h0000_1234);
        end
        check_ret("stall");

        // Flush with enable=0: bubble loaded.
        in_flush = 1'b1;
        step();
        check("flush_en0.RegWrite", {31'd0, RegWrite}, 32'd0);
        check_ret("flush_en0");

        // Flush with enable=1 and a valid instruction: bubble still wins.
        in_enable = 1'b1;
        drive(1'b1, 32'h0000_0077, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        check("flush_en1.RegWrite", {31'd0, RegWrite}, 32'd0);
        check_ret("flush_en1");
        in_flush = 1'b0;
        step();
        check_out("after_flush", 1'b1, 5'd8, 32'h0000_0077);

        // Async reset between edges clears outputs before the next clk edge.
        drive(1'b1, 32'h0000_0099, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        check_out("pre_reset", 1'b1, 5'd9, 32'h0000_0099);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 1'b0, 5'd0, 32'h0000_0000);
        exp_ret = 0;
        check_ret("async_reset");
        #1;
        reset = 1'b0;
        // First instruction after reset needs one enabled edge.
        drive(1'b1, 32'h0000_00AA, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        check("post_reset_before_edge.RegWrite", {31'd0, RegWrite}, 32'd0);
        step();
        check_out("post_reset", 1'b1, 5'd10, 32'h0000_00AA);
        check_ret("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
